// File: rtl/regfile_pkg.sv
// Shared types, defaults and write-port priority helper for the register file.
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  // Widest write-port count the priority helper handles.
  localparam int MAX_WR       = 8;

  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]             word_t;

  // Keep only the highest set bit of a per-port hit vector. The highest port
  // index wins both for the array update and for the bypass path.
  function automatic logic [MAX_WR-1:0] prio_sel(input logic [MAX_WR-1:0] hits);
    logic found;
    prio_sel = '0;
    found    = 1'b0;
    for (int k = MAX_WR - 1; k >= 0; k--) begin
      if (hits[k] && !found) begin
        prio_sel[k] = 1'b1;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array: writes clear, issue sets (set wins), flush clears everything.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR-1:0][AW-1:0]    waddr,
  input  logic                         iss_valid,
  input  logic [AW-1:0]                iss_rd,
  input  logic                         flush,
  input  logic [NUM_RD-1:0][AW-1:0]    raddr,
  input  logic [NUM_RD-1:0]            wr_hit,
  output logic [NUM_RD-1:0]            rbusy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy state: clears first, then the issue set so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++)
      if (we[k]) busy_d[waddr[k]] = 1'b0;
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    if (flush) busy_d = '0;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy register; reset clears the whole scoreboard immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Lookup; with bypass a same-cycle write delivers the data, so no stall.
  always_comb begin
    rbusy = '0;
    for (int j = 0; j < NUM_RD; j++)
      rbusy[j] = busy_q[raddr[j]] && !((BYPASS != 0) && wr_hit[j]);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*XLEN-1:0]   wdata_i,
  input  logic [NUM_RD*AW-1:0]     raddr_i,
  output logic [NUM_RD*XLEN-1:0]   rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic                     iss_valid_i,
  input  logic [AW-1:0]            iss_rd_i,
  input  logic                     flush_i
);

  if (NUM_RD < 1 || NUM_WR < 1 || NUM_WR > MAX_WR || NUM_REGS < 2 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_cfg
    $error("regfile_mp: need NUM_RD>=1, 1<=NUM_WR<=MAX_WR, NUM_REGS a power of two >=2");
  end

  logic [NUM_WR-1:0][AW-1:0]     waddr;
  logic [NUM_WR-1:0][XLEN-1:0]   wdata;
  logic [NUM_RD-1:0][AW-1:0]     raddr;
  logic [NUM_RD-1:0][XLEN-1:0]   rdata;
  logic [NUM_RD-1:0]             wr_hit;
  logic [NUM_REGS-1:0][XLEN-1:0] reg_q, reg_d;

  assign waddr   = waddr_i;
  assign wdata   = wdata_i;
  assign raddr   = raddr_i;
  assign rdata_o = rdata;

  // Array update: per register, pick the highest enabled port targeting it.
  always_comb begin
    logic [MAX_WR-1:0] hits, sel;
    reg_d = reg_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      hits = '0;
      for (int k = 0; k < NUM_WR; k++)
        hits[k] = we_i[k] && (waddr[k] == AW'(r));
      sel = prio_sel(hits);
      for (int k = 0; k < NUM_WR; k++)
        if (sel[k] && !((ZERO_REG != 0) && r == 0)) reg_d[r] = wdata[k];
    end
  end

  // Data array; register 0 never loads when hardwired to zero.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) reg_q <= '0;
    else       reg_q <= reg_d;
  end

  // Read ports: registered value, optionally overridden by a same-cycle write.
  always_comb begin
    logic [MAX_WR-1:0] hits, sel;
    logic              is_zero;
    rdata  = '0;
    wr_hit = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      is_zero  = (ZERO_REG != 0) && (raddr[j] == '0);
      rdata[j] = reg_q[raddr[j]];
      hits     = '0;
      for (int k = 0; k < NUM_WR; k++)
        hits[k] = we_i[k] && (waddr[k] == raddr[j]);
      sel       = prio_sel(hits);
      wr_hit[j] = (|hits) && !is_zero;
      if ((BYPASS != 0) && wr_hit[j])
        for (int k = 0; k < NUM_WR; k++)
          if (sel[k]) rdata[j] = wdata[k];
      if (is_zero) rdata[j] = '0;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst_i),
    .we        (we_i),
    .waddr     (waddr),
    .iss_valid (iss_valid_i),
    .iss_rd    (iss_rd_i),
    .flush     (flush_i),
    .raddr     (raddr),
    .wr_hit    (wr_hit),
    .rbusy     (rbusy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dut_a (no bypass, 1 write port), dut_b (bypass, 2 write ports).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;

  logic [0:0]  we_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [1:0]  rbusy_a;
  logic        iss_valid_a;
  logic [4:0]  iss_rd_a;
  logic        flush_a;

  logic [1:0]  we_b;
  logic [9:0]  waddr_b;
  logic [63:0] wdata_b;
  logic [9:0]  raddr_b;
  logic [63:0] rdata_b;
  logic [1:0]  rbusy_b;
  logic        iss_valid_b;
  logic [4:0]  iss_rd_b;
  logic        flush_b;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_i(rst), .we_i(we_a), .waddr_i(waddr_a), .wdata_i(wdata_a),
    .raddr_i(raddr_a), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
    .iss_valid_i(iss_valid_a), .iss_rd_i(iss_rd_a), .flush_i(flush_a)
  );

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_i(rst), .we_i(we_b), .waddr_i(waddr_b), .wdata_i(wdata_b),
    .raddr_i(raddr_b), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .iss_valid_i(iss_valid_b), .iss_rd_i(iss_rd_b), .flush_i(flush_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic want(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) passed++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    we_a = '0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
    iss_valid_a = 1'b0; iss_rd_a = '0; flush_a = 1'b0;
    we_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
    iss_valid_b = 1'b0; iss_rd_b = '0; flush_b = 1'b0;

    // 1: reset state, then write r5 with no bypass
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr_a = {5'd0, 5'd5};
    #1;
    want("rst_rdata_a", 32'h0); got(rdata_a[31:0]);
    want("rst_rbusy_a", 32'h0); got(32'(rbusy_a));
    want("rst_rdata_b", 32'h0); got(rdata_b[31:0]);
    tick();
    want("rst_holds_write", 32'h0); got(rdata_a[31:0]);
    rst = 1'b0;
    #1;
    want("nobyp_same_cycle", 32'h0); got(rdata_a[31:0]);
    tick();
    we_a = 1'b0;
    want("nobyp_next_cycle", 32'hDEADBEEF); got(rdata_a[31:0]);

    // 2: bypass on read port 1
    we_b = 2'b01; waddr_b = {5'd0, 5'd7}; wdata_b = {32'h0, 32'h12345678}; raddr_b = {5'd7, 5'd0};
    #1;
    want("bypass_same_cycle", 32'h12345678); got(rdata_b[63:32]);
    tick();
    we_b = 2'b00;
    want("bypass_registered", 32'h12345678); got(rdata_b[63:32]);

    // 3: zero register ignores write and issue
    we_b = 2'b01; waddr_b = {5'd0, 5'd0}; wdata_b = {32'h0, 32'hFFFFFFFF};
    iss_valid_b = 1'b1; iss_rd_b = 5'd0; raddr_b = {5'd0, 5'd0};
    #1;
    want("zero_rd0_same", 32'h0); got(rdata_b[31:0]);
    want("zero_rd1_same", 32'h0); got(rdata_b[63:32]);
    want("zero_busy_same", 32'h0); got(32'(rbusy_b));
    tick();
    we_b = 2'b00; iss_valid_b = 1'b0;
    #1;
    want("zero_rd0_after", 32'h0); got(rdata_b[31:0]);
    want("zero_rd1_after", 32'h0); got(rdata_b[63:32]);
    want("zero_busy_after", 32'h0); got(32'(rbusy_b));

    // 4: two ports write r3, port 1 wins
    we_b = 2'b11; waddr_b = {5'd3, 5'd3}; wdata_b = {32'h0000BBBB, 32'hAAAA0000}; raddr_b = {5'd0, 5'd3};
    #1;
    want("conflict_bypass", 32'h0000BBBB); got(rdata_b[31:0]);
    tick();
    we_b = 2'b00;
    want("conflict_array", 32'h0000BBBB); got(rdata_b[31:0]);

    // 5: set/clear race on r9, no bypass
    iss_valid_a = 1'b1; iss_rd_a = 5'd9; raddr_a = {5'd9, 5'd0};
    #1;
    want("race_busy_c1", 32'h0); got(32'(rbusy_a[1]));
    tick();
    iss_valid_a = 1'b0;
    want("race_busy_c2", 32'h1); got(32'(rbusy_a[1]));
    tick();
    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h00000099; iss_valid_a = 1'b1; iss_rd_a = 5'd9;
    #1;
    want("race_busy_c3_unmasked", 32'h1); got(32'(rbusy_a[1]));
    tick();
    we_a = 1'b0; iss_valid_a = 1'b0;
    want("race_set_wins", 32'h1); got(32'(rbusy_a[1]));
    want("race_data", 32'h00000099); got(rdata_a[63:32]);
    we_a = 1'b1; wdata_a = 32'h0000009A;
    tick();
    we_a = 1'b0;
    want("race_clear", 32'h0); got(32'(rbusy_a[1]));

    // 5b: bypass masks busy on a same-cycle write
    iss_valid_b = 1'b1; iss_rd_b = 5'd9; raddr_b = {5'd9, 5'd0};
    tick();
    iss_valid_b = 1'b0;
    want("byp_busy_set", 32'h1); got(32'(rbusy_b[1]));
    we_b = 2'b01; waddr_b = {5'd0, 5'd9}; wdata_b = {32'h0, 32'h00000055};
    #1;
    want("byp_busy_masked", 32'h0); got(32'(rbusy_b[1]));
    want("byp_busy_data", 32'h00000055); got(rdata_b[63:32]);
    tick();
    we_b = 2'b00;

    // 6: flush overrides issue, then async reset mid-cycle
    iss_valid_a = 1'b1; iss_rd_a = 5'd1;
    tick();
    iss_rd_a = 5'd2;
    tick();
    iss_rd_a = 5'd4;
    tick();
    iss_valid_a = 1'b0; raddr_a = {5'd4, 5'd1};
    #1;
    want("pre_flush_busy", 32'h3); got(32'(rbusy_a));
    iss_valid_a = 1'b1; iss_rd_a = 5'd6; flush_a = 1'b1;
    tick();
    iss_valid_a = 1'b0; flush_a = 1'b0;
    want("flush_r1_r4", 32'h0); got(32'(rbusy_a));
    raddr_a = {5'd6, 5'd2};
    #1;
    want("flush_r2_r6", 32'h0); got(32'(rbusy_a));
    iss_valid_a = 1'b1; iss_rd_a = 5'd8; raddr_a = {5'd5, 5'd8};
    tick();
    iss_valid_a = 1'b0;
    want("r8_busy", 32'h1); got(32'(rbusy_a));
    want("r5_kept", 32'hDEADBEEF); got(rdata_a[63:32]);
    #2;
    rst = 1'b1;
    #1;
    want("async_rst_busy", 32'h0); got(32'(rbusy_a));
    want("async_rst_data", 32'h0); got(rdata_a[63:32]);
    tick();
    rst = 1'b0;

    if (q.size() != 0) begin
      checks++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
